tea_iter_core: RTL and testbench
================================

TEA_ITER_CORE -- requirements
Module: tea_iter_core

Parameters
REQ-001 ROUNDS, default 32: total TEA rounds per block; SHALL be a multiple of UNROLL, range 1..64.
REQ-002 UNROLL, default 4: TEA rounds evaluated combinationally per clock cycle; SHALL divide ROUNDS.

Interface
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ena  in  1  clock enable; low freezes all state, outputs hold.
REQ-006 in_valid  in  1  input block and controls presented.
REQ-007 in_ready  out  1  core can accept a block this cycle.
REQ-008 encrypt  in  1  1 = encrypt, 0 = decrypt; sampled on accept.
REQ-009 inBlock64  in  64  v0 = [31:0], v1 = [63:32].
REQ-010 key  in  128  k[i] = key[32*i+31:32*i], i = 0..3; sampled on accept.
REQ-011 out_valid  out  1  outBlock64 holds a finished result.
REQ-012 out_ready  in  1  consumer takes the result.
REQ-013 outBlock64  out  64  processed block, same v0/v1 packing as input.
REQ-014 busy  out  1  high in RUN state.

Function
REQ-015 Accept SHALL occur when in_valid & in_ready & ena; block, key and mode SHALL be latched, and inputs SHALL be ignored otherwise.
REQ-016 FSM states: IDLE -> RUN on accept; RUN -> DONE when the round counter reaches ROUNDS/UNROLL-1 with ena high; DONE -> IDLE on out_ready & ena.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-018 Each RUN cycle with ena high SHALL apply UNROLL consecutive rounds and increment the round counter.
REQ-019 Latency: out_valid SHALL rise exactly ROUNDS/UNROLL enabled cycles after the accept edge (8 for the defaults).
REQ-020 Encrypt round, DELTA = 32'h9E3779B9: sum += DELTA; v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1); v1 += ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3).
REQ-021 Encrypt SHALL start with sum = 0.
REQ-022 Decrypt round SHALL be the exact inverse: the v1 update is subtracted first, then v0, then sum -= DELTA.
REQ-023 Decrypt SHALL start with sum = DELTA*ROUNDS mod 2^32.
REQ-024 Arithmetic SHALL be 32-bit modulo 2^32 throughout; shifts are logical.
REQ-025 outBlock64 SHALL hold stable in DONE until the handshake completes, including while out_ready is low indefinitely.
REQ-026 in_valid during RUN or DONE SHALL NOT disturb the operation in progress; the block is accepted in a later IDLE cycle.
REQ-027 ena low in any state SHALL freeze state, counter, sum and data; no accept or handshake completes that cycle.

Reset
REQ-028 rst high SHALL, on the next clk edge and regardless of ena, force IDLE with the round counter at 0 and sum at 0.
REQ-029 Reset SHALL clear outBlock64 to 0; out_valid, busy SHALL go to 0 and in_ready to 1.
REQ-030 rst during RUN or DONE SHALL discard the block in progress; no out_valid is produced for it.

Configuration
REQ-031 Macro TEA_BLOCK_COUNT_EN defined: adds output blk_count (out, 32). It SHALL increment on each completed output handshake, wrap 32'hFFFFFFFF -> 0, and be cleared by rst.
REQ-032 Macro TEA_BLOCK_COUNT_EN undefined: the port and counter SHALL be absent, with identical behaviour otherwise.

Verification
REQ-033 rst, encrypt=1, key=0, inBlock64=0, defaults -> out_valid 8 cycles after accept; outBlock64 = {32'h94BAA940, 32'h41EA3A0A}.
REQ-034 Decrypt of the REQ-033 output with key=0 -> outBlock64 = 64'h0.
REQ-035 Random key/block, UNROLL in {1,4,32}, encrypt then decrypt -> plaintext restored; latency = 32/UNROLL cycles.
REQ-036 out_ready held low 20 cycles in DONE, in_valid pulsed meanwhile -> outBlock64 stable; in_ready low; second block accepted only after the handshake.
REQ-037 ena low 5 cycles mid-RUN -> out_valid delayed exactly 5 cycles; result unchanged. Then rst asserted mid-RUN -> IDLE next edge, out_valid never rises.
REQ-038 With TEA_BLOCK_COUNT_EN: 3 handshakes -> blk_count = 3; preloaded to 32'hFFFFFFFF, one handshake -> blk_count = 0.

Source files
------------

// File: rtl/tea_iter_core.sv
// -----------------------------------------------------------------------------
// tea_iter_core
//   Iterative TEA (Tiny Encryption Algorithm) block cipher core. A 64-bit block
//   is accepted together with a 128-bit key and a mode bit. The core then runs
//   ROUNDS TEA rounds, UNROLL rounds per enabled clock cycle, and presents the
//   result until the consumer takes it.
//
// Parameters
//   ROUNDS  total TEA rounds per block (1..64, a multiple of UNROLL)
//   UNROLL  rounds evaluated combinationally per clock cycle
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset (works regardless of ena)
//   ena         clock enable; low freezes every register
//   in_valid    producer presents block/key/mode
//   in_ready    core is IDLE and can accept a block
//   encrypt     1 = encrypt, 0 = decrypt (latched on accept)
//   inBlock64   input block, v0 = [31:0], v1 = [63:32]
//   key         k[i] = key[32*i+31 : 32*i]  (latched on accept)
//   out_valid   outBlock64 holds a finished result (DONE state)
//   out_ready   consumer takes the result
//   outBlock64  result block, same packing as inBlock64
//   busy        core is running rounds
//   blk_count   completed output handshakes, wrapping (only when the macro
//               TEA_BLOCK_COUNT_EN is defined)
//
// Build option
//   TEA_BLOCK_COUNT_EN  adds the blk_count output and its counter.
// -----------------------------------------------------------------------------
module tea_iter_core #(
  parameter int ROUNDS = 32,
  parameter int UNROLL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         encrypt,
  input  logic [63:0]  inBlock64,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  outBlock64,
  output logic         busy
`ifdef TEA_BLOCK_COUNT_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  localparam logic [31:0] DELTA    = 32'h9E37_79B9;
  localparam int          STEPS    = ROUNDS / UNROLL;
  localparam logic [6:0]  LAST_CNT = 7'(STEPS - 1);
  // Decrypt walks the sum back down from its final encrypt value.
  localparam logic [63:0] SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
  localparam logic [31:0] SUM_DEC  = SUM_PROD[31:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [6:0]    cnt_r;
  logic [31:0]   v0_r;
  logic [31:0]   v1_r;
  logic [31:0]   sum_r;
  logic [127:0]  key_r;
  logic          enc_r;
  logic [31:0]   v0_s;
  logic [31:0]   v1_s;
  logic [31:0]   sum_s;
  logic          accept_s;

  // TEA mixing function shared by both half-rounds and both directions.
  function automatic logic [31:0] tea_mix(input logic [31:0] x,
                                          input logic [31:0] s,
                                          input logic [31:0] ka,
                                          input logic [31:0] kb);
    tea_mix = ((x << 32'd4) + ka) ^ (x + s) ^ ((x >> 32'd5) + kb);
  endfunction

  assign accept_s   = (state_r == ST_IDLE) && in_valid && ena;
  assign outBlock64 = {v1_r, v0_r};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; ena low holds the current state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ena && (cnt_r == LAST_CNT)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (ena && out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode; each flag is owned by exactly one state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: in_ready  = 1'b1;
      ST_RUN:  busy      = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // UNROLL chained TEA rounds from the current registered state.
  always_comb begin
    v0_s  = v0_r;
    v1_s  = v1_r;
    sum_s = sum_r;
    for (int i = 0; i < UNROLL; i++) begin
      if (enc_r) begin
        sum_s = sum_s + DELTA;
        v0_s  = v0_s + tea_mix(v1_s, sum_s, key_r[31:0],  key_r[63:32]);
        v1_s  = v1_s + tea_mix(v0_s, sum_s, key_r[95:64], key_r[127:96]);
      end else begin
        v1_s  = v1_s - tea_mix(v0_s, sum_s, key_r[95:64], key_r[127:96]);
        v0_s  = v0_s - tea_mix(v1_s, sum_s, key_r[31:0],  key_r[63:32]);
        sum_s = sum_s - DELTA;
      end
    end
  end

  // Datapath registers: latch on accept, advance while running, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_r  <= 32'd0;
      v1_r  <= 32'd0;
      sum_r <= 32'd0;
      cnt_r <= 7'd0;
      key_r <= 128'd0;
      enc_r <= 1'b0;
    end else if (ena) begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            v0_r  <= inBlock64[31:0];
            v1_r  <= inBlock64[63:32];
            key_r <= key;
            enc_r <= encrypt;
            sum_r <= encrypt ? 32'd0 : SUM_DEC;
            cnt_r <= 7'd0;
          end else begin
            cnt_r <= 7'd0;
          end
        end
        ST_RUN: begin
          v0_r  <= v0_s;
          v1_r  <= v1_s;
          sum_r <= sum_s;
          cnt_r <= cnt_r + 7'd1;
        end
        ST_DONE: begin
          cnt_r <= 7'd0;
        end
        default: begin
          cnt_r <= 7'd0;
        end
      endcase
    end else begin
      cnt_r <= cnt_r;
    end
  end

`ifdef TEA_BLOCK_COUNT_EN
  // Completed-handshake counter; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_count <= 32'd0;
    end else if (ena && out_ready && (state_r == ST_DONE)) begin
      blk_count <= blk_count + 32'd1;
    end else begin
      blk_count <= blk_count;
    end
  end
`endif

endmodule

// File: tb/tb_tea_iter_core.sv
// -----------------------------------------------------------------------------
// tb_tea_iter_core
//   Directed bench for tea_iter_core: a vector table of known/derived TEA
//   results on the default core, plus hand-written sequences for back-pressure,
//   clock-enable stalls, mid-run reset and UNROLL = 1 / 4 / 32 latency.
// -----------------------------------------------------------------------------
module tb_tea_iter_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         in_valid;
  logic         encrypt;
  logic         out_ready;
  logic [63:0]  inBlock64;
  logic [127:0] key;
  logic         in_ready, out_valid, busy;
  logic [63:0]  outBlock64;
  logic         u1_in_ready, u1_out_valid, u1_busy;
  logic [63:0]  u1_out;
  logic         u32_in_ready, u32_out_valid, u32_busy;
  logic [63:0]  u32_out;
`ifdef TEA_BLOCK_COUNT_EN
  logic [31:0]  blk_count, u1_blk_count, u32_blk_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tea_iter_core dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .encrypt(encrypt), .inBlock64(inBlock64), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .outBlock64(outBlock64), .busy(busy)
`ifdef TEA_BLOCK_COUNT_EN
    , .blk_count(blk_count)
`endif
  );

  tea_iter_core #(.ROUNDS(32), .UNROLL(1)) dut_u1 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(u1_in_ready),
    .encrypt(encrypt), .inBlock64(inBlock64), .key(key), .out_valid(u1_out_valid),
    .out_ready(out_ready), .outBlock64(u1_out), .busy(u1_busy)
`ifdef TEA_BLOCK_COUNT_EN
    , .blk_count(u1_blk_count)
`endif
  );

  tea_iter_core #(.ROUNDS(32), .UNROLL(32)) dut_u32 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(u32_in_ready),
    .encrypt(encrypt), .inBlock64(inBlock64), .key(key), .out_valid(u32_out_valid),
    .out_ready(out_ready), .outBlock64(u32_out), .busy(u32_busy)
`ifdef TEA_BLOCK_COUNT_EN
    , .blk_count(u32_blk_count)
`endif
  );

  // Textbook 32-round TEA used to derive expected ciphertexts.
  function automatic logic [63:0] tea_ref(input logic enc, input logic [127:0] k,
                                          input logic [63:0] b);
    logic [31:0] y, z, s, d;
    d = 32'h9E3779B9;
    y = b[31:0];
    z = b[63:32];
    s = enc ? 32'd0 : 32'hC6EF3720;
    for (int r = 0; r < 32; r++) begin
      if (enc) begin
        s = s + d;
        y = y + (((z << 4) + k[31:0]) ^ (z + s) ^ ((z >> 5) + k[63:32]));
        z = z + (((y << 4) + k[95:64]) ^ (y + s) ^ ((y >> 5) + k[127:96]));
      end else begin
        z = z - (((y << 4) + k[95:64]) ^ (y + s) ^ ((y >> 5) + k[127:96]));
        y = y - (((z << 4) + k[31:0]) ^ (z + s) ^ ((z >> 5) + k[63:32]));
        s = s - d;
      end
    end
    return {z, y};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one block for one cycle, then scramble the inputs to prove latching.
  task automatic accept(input logic enc, input logic [127:0] k, input logic [63:0] b);
    chk("ready_before_accept", 64'(in_ready), 64'd1);
    encrypt   = enc;
    key       = k;
    inBlock64 = b;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    encrypt   = ~enc;
    key       = ~k;
    inBlock64 = ~b;
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    if (lat >= 200) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after_hs", 64'(out_valid), 64'd0);
    chk("in_ready_after_hs", 64'(in_ready), 64'd1);
  endtask

  // Run one block through all three UNROLL variants in parallel.
  task automatic multi_run(input logic enc, input logic [127:0] k,
                           input logic [63:0] b, input logic [63:0] exp);
    int l1, l4, l32;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    encrypt = enc; key = k; inBlock64 = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    key = ~k;
    l1 = -1; l4 = -1; l32 = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (l1 < 0 && u1_out_valid) l1 = c;
      if (l4 < 0 && out_valid) l4 = c;
      if (l32 < 0 && u32_out_valid) l32 = c;
    end
    chk("lat_unroll1", 64'(l1), 64'd32);
    chk("lat_unroll4", 64'(l4), 64'd8);
    chk("lat_unroll32", 64'(l32), 64'd1);
    chk("res_unroll1", u1_out, exp);
    chk("res_unroll4", outBlock64, exp);
    chk("res_unroll32", u32_out, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic         enc;
    logic [127:0] k;
    logic [63:0]  blk;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0]  res, hold, snap, blk_b;
    logic [127:0] k_b;
    int           lat;
    logic         seen;

    // Vector table: encrypt entries, each followed by its decrypt round trip.
    vecs[0] = '{1'b1, 128'd0, 64'd0, 64'h94BAA940_41EA3A0A};
    vecs[1] = '{1'b0, 128'd0, 64'h94BAA940_41EA3A0A, 64'd0};
    vecs[2] = '{1'b1, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0,
                64'hDEADBEEF_01234567, 64'd0};
    vecs[2].exp = tea_ref(1'b1, vecs[2].k, vecs[2].blk);
    vecs[3] = '{1'b0, vecs[2].k, vecs[2].exp, vecs[2].blk};
    vecs[4] = '{1'b1, {128{1'b1}}, {64{1'b1}}, 64'd0};
    vecs[4].exp = tea_ref(1'b1, vecs[4].k, vecs[4].blk);
    vecs[5] = '{1'b0, vecs[4].k, vecs[4].exp, {64{1'b1}}};

    // Reset with ena low: reset must still take effect.
    rst = 1'b1; ena = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    encrypt = 1'b0; key = 128'd0; inBlock64 = 64'd0;
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_block", outBlock64, 64'd0);
    rst = 1'b0;
    ena = 1'b1;
    step();

    foreach (vecs[i]) begin
      accept(vecs[i].enc, vecs[i].k, vecs[i].blk);
      wait_valid(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
      chk($sformatf("vec%0d_result", i), outBlock64, vecs[i].exp);
      handshake();
    end

    // ena low in IDLE: no accept.
    ena = 1'b0; in_valid = 1'b1; inBlock64 = 64'h1;
    step();
    chk("idle_ena_low_no_accept", 64'(busy), 64'd0);
    chk("idle_ena_low_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0; ena = 1'b1;

    // Back-pressure: result holds 20 cycles, new block waits for the handshake.
    k_b   = 128'h11111111_22222222_33333333_44444444;
    blk_b = 64'hCAFEBABE_8BADF00D;
    accept(1'b1, vecs[2].k, 64'h00000001_00000002);
    wait_valid(lat);
    hold = outBlock64;
    chk("bp_first_result", hold, tea_ref(1'b1, vecs[2].k, 64'h00000001_00000002));
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        encrypt = 1'b1; key = k_b; inBlock64 = blk_b; in_valid = 1'b1;
      end
      step();
      chk("bp_hold_block", outBlock64, hold);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle_after_hs", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_second_accepted", 64'(busy), 64'd1);
    wait_valid(lat);
    chk("bp_second_latency", 64'(lat), 64'd8);
    chk("bp_second_result", outBlock64, tea_ref(1'b1, k_b, blk_b));
    handshake();

    // ena low 5 cycles mid-RUN: latency grows by exactly 5, data frozen.
    accept(1'b1, k_b, 64'h0BADC0DE_12345678);
    repeat (3) step();
    snap = outBlock64;
    ena = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_frozen_data", outBlock64, snap);
      chk("stall_busy", 64'(busy), 64'd1);
    end
    ena = 1'b1;
    wait_valid(lat);
    chk("stall_latency", 64'(lat + 8), 64'd13);
    chk("stall_result", outBlock64, tea_ref(1'b1, k_b, 64'h0BADC0DE_12345678));
    // ena low in DONE: handshake must not complete.
    ena = 1'b0; out_ready = 1'b1;
    step();
    chk("done_ena_low_hold", 64'(out_valid), 64'd1);
    ena = 1'b1;
    step();
    out_ready = 1'b0;
    chk("done_hs_after_ena", 64'(out_valid), 64'd0);

    // Reset mid-RUN discards the block.
    accept(1'b1, k_b, 64'h55555555_AAAAAAAA);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_block", outBlock64, 64'd0);
    seen = 1'b0;
    repeat (20) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_out_valid", 64'(seen), 64'd0);

    // UNROLL 1 / 4 / 32: latency and encrypt/decrypt round trip.
    multi_run(1'b1, vecs[2].k, 64'h76543210_FEDCBA98,
              tea_ref(1'b1, vecs[2].k, 64'h76543210_FEDCBA98));
    multi_run(1'b0, vecs[2].k, tea_ref(1'b1, vecs[2].k, 64'h76543210_FEDCBA98),
              64'h76543210_FEDCBA98);

`ifdef TEA_BLOCK_COUNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("cnt_after_rst", 64'(blk_count), 64'd0);
    for (int n = 0; n < 3; n++) begin
      accept(1'b1, 128'd0, 64'(n));
      wait_valid(lat);
      handshake();
    end
    chk("cnt_three", 64'(blk_count), 64'd3);
    force dut.blk_count = 32'hFFFFFFFF;
    #1;
    release dut.blk_count;
    accept(1'b1, 128'd0, 64'd9);
    wait_valid(lat);
    handshake();
    chk("cnt_wrap", 64'(blk_count), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
